// File: rtl/calc_alu_pkg.sv
// ============================================================================
// Package : calc_pkg
// Purpose : Shared definitions for the calculator ALU and its display stage.
//           Holds the operation codes, the display control codes and the
//           ALU state encoding.
// Config  : CALC_ALU_DIV_EN selects whether the divider is built. The package
//           content is the same in both builds.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  // Operation codes carried on the op port
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Display control codes carried on the contr port
  localparam logic [2:0] CONTR_POS = 3'd0;
  localparam logic [2:0] CONTR_NEG = 3'd1;
  localparam logic [2:0] CONTR_ERR = 3'd2;
  localparam logic [2:0] CONTR_DOT = 3'd4;

  // ALU sequencer states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_FIN  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module  : seq_divider
// Purpose : Restoring divider. It produces one quotient bit per clock and
//           DIV_W quotient bits in total.
// Ports   : clk, rst_n      - clock, synchronous active-low reset
//           start_i         - load the operands (ignored while running)
//           dividend_i      - DIV_W-bit dividend
//           divisor_i       - OP_W-bit divisor (must be nonzero)
//           done_o          - high during the cycle whose clock edge
//                             produces the final quotient bit
//           quot_o          - quotient, valid from the cycle after done_o
// Config  : Instantiated only when CALC_ALU_DIV_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int OP_W  = 6,
  parameter int DIV_W = OP_W + 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DIV_W-1:0] dividend_i,
  input  logic [OP_W-1:0]  divisor_i,
  output logic             done_o,
  output logic [DIV_W-1:0] quot_o
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic              run_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OP_W-1:0]   rem_q, rem_d;
  logic [OP_W-1:0]   dvs_q;
  // Dividend bits shift out at the top while quotient bits shift in at the
  // bottom, so one register serves both purposes.
  logic [DIV_W-1:0]  num_q;
  logic [OP_W:0]     trial_w;
  logic [OP_W:0]     diff_w;
  logic              ge_w;

  always_comb begin
    trial_w = {rem_q, num_q[DIV_W-1]};
    ge_w    = (trial_w >= {1'b0, dvs_q});
    diff_w  = trial_w - {1'b0, dvs_q};
    // The partial remainder is always below the divisor, so it fits in OP_W bits.
    rem_d   = ge_w ? diff_w[OP_W-1:0] : trial_w[OP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      num_q <= '0;
    end else if (start_i && !run_q) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      rem_q <= '0;
      dvs_q <= divisor_i;
      num_q <= dividend_i;
    end else if (run_q) begin
      num_q <= {num_q[DIV_W-2:0], ge_w};
      rem_q <= rem_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DIV_W - 1)) run_q <= 1'b0;
    end
  end

  // done_o is combinational so that the caller can leave its wait state on
  // the same edge that produces the last quotient bit.
  assign done_o = run_q && (cnt_q == CNT_W'(DIV_W - 1));
  assign quot_o = num_q;

endmodule

`default_nettype wire

// File: rtl/calc_alu.sv
// ============================================================================
// Module  : calc_alu
// Purpose : Multi-cycle calculator ALU. It performs add, subtract, shift-add
//           multiply and fixed-point (x100) divide on unsigned operands. It
//           produces a magnitude and a display code.
// Ports   : clk, rst_n   - clock, synchronous active-low reset
//           start        - request, sampled only in IDLE
//           op, a, b     - operation and operands, latched on acceptance
//           busy         - operation in progress (through FIN)
//           done         - one-cycle pulse when data/contr update
//           data, contr  - result magnitude and display code (held)
// Config  : CALC_ALU_DIV_EN defined   -> divider built (op=3 divides)
//           CALC_ALU_DIV_EN undefined -> op=3 reports an error
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_alu
  import calc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int IND_ALU = 11,
  parameter int C_ALU   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [OP_W-1:0]    a,
  input  logic [OP_W-1:0]    b,
  output logic               busy,
  output logic               done,
  output logic [IND_ALU-1:0] data,
  output logic [C_ALU-1:0]   contr
);

  localparam int CNT_W = $clog2(OP_W + 1);
  localparam int DIV_W = OP_W + 7;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     a_q, b_q;
  logic [1:0]          op_q;
  logic [2*OP_W-1:0]   acc_q, mcand_q;
  logic [OP_W-1:0]     mplier_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                done_q;
  logic [IND_ALU-1:0]  data_q;
  logic [C_ALU-1:0]    contr_q;

  logic                accept_w;
  logic [31:0]         res_w;
  logic [2:0]          res_c_w;
  logic                ovf_w;
  logic [IND_ALU-1:0]  fin_data_w;
  logic [C_ALU-1:0]    fin_contr_w;

  assign accept_w = (state_q == ST_IDLE) && start;

`ifdef CALC_ALU_DIV_EN
  logic             div_start_w;
  logic             div_done_w;
  logic [DIV_W-1:0] div_quot_w;
  logic [DIV_W-1:0] dividend_w;

  // The divider loads directly from the ports on the acceptance edge, so
  // its bit count lines up with the cycles spent in DIV.
  assign dividend_w  = DIV_W'(a) * DIV_W'(100);
  assign div_start_w = accept_w && (op == OP_DIV) && (b != '0);

  seq_divider #(
    .OP_W  (OP_W),
    .DIV_W (DIV_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start_w),
    .dividend_i (dividend_w),
    .divisor_i  (b),
    .done_o     (div_done_w),
    .quot_o     (div_quot_w)
  );
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MUL:  state_d = ST_MUL;
`ifdef CALC_ALU_DIV_EN
            // A zero divisor skips the divider and reports an error straight away.
            OP_DIV:  state_d = (b == '0) ? ST_FIN : ST_DIV;
`endif
            default: state_d = ST_FIN;
          endcase
        end
      end
      ST_MUL:  if (cnt_q == CNT_W'(OP_W - 1)) state_d = ST_FIN;
`ifdef CALC_ALU_DIV_EN
      ST_DIV:  if (div_done_w) state_d = ST_FIN;
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result formation. This logic is only consumed in FIN.
  always_comb begin
    res_w   = 32'd0;
    res_c_w = CONTR_POS;
    case (op_q)
      OP_ADD: res_w = 32'(a_q) + 32'(b_q);
      OP_SUB: begin
        if (a_q >= b_q) begin
          res_w = 32'(a_q) - 32'(b_q);
        end else begin
          res_w   = 32'(b_q) - 32'(a_q);
          res_c_w = CONTR_NEG;
        end
      end
      OP_MUL: res_w = 32'(acc_q);
      default: begin
`ifdef CALC_ALU_DIV_EN
        if (b_q == '0) begin
          res_c_w = CONTR_ERR;
        end else begin
          res_w   = 32'(div_quot_w);
          res_c_w = CONTR_DOT;
        end
`else
        res_c_w = CONTR_ERR;
`endif
      end
    endcase

    // The display stage supports at most four digits and IND_ALU bits.
    ovf_w = (res_w > 32'd9999) || (res_w >= (32'd1 << IND_ALU));
    if (ovf_w || (res_c_w == CONTR_ERR)) begin
      fin_data_w  = '0;
      fin_contr_w = C_ALU'(CONTR_ERR);
    end else begin
      fin_data_w  = res_w[IND_ALU-1:0];
      fin_contr_w = C_ALU'(res_c_w);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      data_q   <= '0;
      contr_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_FIN);

      if (accept_w) begin
        a_q      <= a;
        b_q      <= b;
        op_q     <= op;
        acc_q    <= '0;
        mcand_q  <= {{OP_W{1'b0}}, a};
        mplier_q <= b;
        cnt_q    <= '0;
      end

      // Shift-add multiply: one multiplier bit is consumed per cycle, LSB first.
      if (state_q == ST_MUL) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end

      if (state_q == ST_FIN) begin
        data_q  <= fin_data_w;
        contr_q <= fin_contr_w;
      end
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign data  = data_q;
  assign contr = contr_q;

endmodule

`default_nettype wire

// File: tb/tb_calc_alu.sv
// ============================================================================
// Module  : tb_calc_alu
// Purpose : Self-checking bench for calc_alu. It runs directed cases and
//           random operations against an arithmetic reference model.
// Config  : The model follows CALC_ALU_DIV_EN in the same way as the design.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_alu;

  localparam int OP_W    = 6;
  localparam int IND_ALU = 11;
  localparam int C_ALU   = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [1:0]         op;
  logic [OP_W-1:0]    a, b;
  logic               busy, done;
  logic [IND_ALU-1:0] data;
  logic [C_ALU-1:0]   contr;

  int n_checks = 0;
  int n_fail   = 0;

  calc_alu #(.OP_W(OP_W), .IND_ALU(IND_ALU), .C_ALU(C_ALU)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .data  (data),
    .contr (contr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operation rules
  task automatic model(input int ai, input int bi, input int opi,
                       output int v, output int c, output int lat);
    lat = 2;
    c   = 0;
    v   = 0;
    case (opi)
      0: v = ai + bi;
      1: begin
        if (ai >= bi) v = ai - bi;
        else begin v = bi - ai; c = 1; end
      end
      2: begin v = ai * bi; lat = OP_W + 2; end
      default: begin
`ifdef CALC_ALU_DIV_EN
        if (bi == 0) c = 2;
        else begin v = (ai * 100) / bi; c = 4; lat = OP_W + 9; end
`else
        c = 2;
`endif
      end
    endcase
    if (c != 2 && (v > 9999 || v >= (1 << IND_ALU))) begin v = 0; c = 2; end
    if (c == 2) v = 0;
  endtask

  // Runs one operation. The inputs are scrambled after acceptance. If poke
  // is set, a second start is pulsed mid-operation and must have no effect.
  task automatic run_op(input int ai, input int bi, input int opi,
                        input bit poke, input bit no_sync);
    int v, c, lat, cyc;
    bit extra;
    model(ai, bi, opi, v, c, lat);
    if (!no_sync) @(negedge clk);
    start = 1'b1;
    a = OP_W'(ai);
    b = OP_W'(bi);
    op = 2'(opi);
    @(negedge clk);
    start = 1'b0;
    a = OP_W'($urandom);
    b = OP_W'($urandom);
    op = 2'($urandom);
    cyc = 1;
    check("busy_after_start", 32'(busy), 1);
    while (!done && cyc < 40) begin
      start = (poke && cyc == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 1);
    check("latency", cyc, lat);
    check("data", 32'(data), v);
    check("contr", 32'(contr), c);
    check("busy_at_done", 32'(busy), 0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
    check("data_hold", 32'(data), v);
    if (poke) begin
      extra = 1'b0;
      repeat (OP_W + 12) begin
        @(negedge clk);
        if (done) extra = 1'b1;
      end
      check("no_queued_done", 32'(extra), 0);
    end
  endtask

  initial begin
    int ra, rb, rop;
    bit got_done;
    rst_n = 1'b0;
    start = 1'b0;
    op = 2'd0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_data", 32'(data), 0);
    check("reset_contr", 32'(contr), 0);
    rst_n = 1'b1;

    // Directed cases
    run_op(25, 17, 0, 1'b0, 1'b0);
    run_op(5, 12, 1, 1'b0, 1'b0);
    run_op(9, 9, 1, 1'b0, 1'b0);
    run_op(63, 63, 2, 1'b0, 1'b0);
    run_op(40, 51, 2, 1'b0, 1'b0);
    run_op(7, 3, 3, 1'b0, 1'b0);
    run_op(7, 0, 3, 1'b0, 1'b0);
    run_op(63, 63, 0, 1'b0, 1'b0);
    run_op(0, 63, 1, 1'b0, 1'b0);
    run_op(63, 1, 3, 1'b0, 1'b0);
    run_op(45, 45, 2, 1'b0, 1'b0);
    run_op(7, 3, 3, 1'b1, 1'b0);
    run_op(13, 11, 2, 1'b1, 1'b0);

    // Reset in the middle of a multiply: the operation is abandoned
    @(negedge clk);
    start = 1'b1; a = 6'd40; b = 6'd51; op = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_done", 32'(done), 0);
    check("midreset_data", 32'(data), 0);
    check("midreset_contr", 32'(contr), 0);
    got_done = 1'b0;
    repeat (OP_W + 4) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    check("midreset_no_done", 32'(got_done), 0);
    rst_n = 1'b1;
    run_op(25, 17, 0, 1'b0, 1'b1);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      ra  = int'($urandom_range(0, 63));
      rb  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63));
      rop = int'($urandom_range(0, 3));
      run_op(ra, rb, rop, (i % 10) == 5, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/calc_alu.md
CALC_ALU -- requirements
Module: calc_alu

Interface
REQ-001 SHALL have parameter OP_W, default 6, operand width in bits (unsigned, 0..2^OP_W-1).
REQ-002 SHALL have parameter IND_ALU, default 11, result magnitude width feeding the display stage.
REQ-003 SHALL have parameter C_ALU, default 3, width of the display control code.
REQ-004 SHALL have the following ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  operation request, sampled only in IDLE.
- op  in  2  operation: 0 add, 1 sub, 2 mul, 3 div.
- a  in  OP_W  first operand.
- b  in  OP_W  second operand.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when data/contr update.
- data  out  IND_ALU  result magnitude for display.
- contr  out  C_ALU  display code: 0 positive, 1 negative, 2 error, 4 two-decimal fixed point.

Function
REQ-005 SHALL latch a, b, op on the clk edge where start=1 in IDLE; later input changes SHALL NOT affect that operation.
REQ-006 SHALL ignore start while busy=1; no queuing.
REQ-007 SHALL implement states IDLE, MUL, DIV, FIN: IDLE->FIN for add/sub; IDLE->MUL->FIN; IDLE->DIV->FIN; FIN->IDLE unconditionally.
REQ-008 SHALL assert busy from the cycle after start acceptance until FIN, inclusive; done=1 only in the cycle after FIN, with data/contr updated in that same cycle.
REQ-009 Add: data=a+b, contr=0; latency start-edge to done = 2 cycles.
REQ-010 Sub: a>=b gives data=a-b, contr=0; a<b gives data=b-a, contr=1; a==b gives data=0, contr=0; latency 2 cycles.
REQ-011 Mul: shift-add, one multiplier bit per cycle, OP_W iterations; data=a*b, contr=0; latency OP_W+2 cycles.
REQ-012 Div: restoring division of a*100 by b, DIV_W=OP_W+7 quotient bits, one bit per cycle; data=floor(a*100/b), contr=4; latency DIV_W+2 cycles.
REQ-013 Div with b=0 SHALL give data=0, contr=2, latency 2 cycles.
REQ-014 Any result >= 2^IND_ALU or > 9999 SHALL give data=0, contr=2 (overflow).
REQ-015 data/contr SHALL hold their value between done pulses.

Reset
REQ-016 rst_n=0 at a clk edge SHALL force state IDLE, busy=0, done=0, data=0, contr=0.
REQ-017 Reset during MUL/DIV SHALL abandon the operation with no done pulse; start is accepted on the first edge after rst_n returns high.

Configuration
REQ-018 Macro CALC_ALU_DIV_EN defined: division per REQ-012/013 is compiled in.
REQ-019 Macro CALC_ALU_DIV_EN undefined: no DIV state or divider logic; op=3 SHALL give data=0, contr=2, latency 2 cycles.

Structure
REQ-020 Package calc_pkg SHALL hold op codes (OP_ADD..OP_DIV), contr codes (CONTR_POS=0, CONTR_NEG=1, CONTR_ERR=2, CONTR_DOT=4) and the state type; shared with the display stage.
REQ-021 The divider SHALL be a sub-module seq_divider (start/done handshake, DIV_W-bit quotient), instantiated only under CALC_ALU_DIV_EN.

Verification
REQ-022 a=25,b=17,op=0 -> done 2 cycles after start, data=42, contr=0.
REQ-023 a=5,b=12,op=1 -> data=7, contr=1; a=9,b=9 -> data=0, contr=0.
REQ-024 a=63,b=63,op=2 -> data=0, contr=2 (3969 overflow); a=40,b=51 -> data=2040, contr=0 after 8 cycles.
REQ-025 a=7,b=3,op=3 -> data=233, contr=4 after 15 cycles; b=0 -> data=0, contr=2 after 2 cycles.
REQ-026 start pulsed again mid-DIV -> ignored, single done; rst_n low mid-MUL -> no done, outputs 0, next start accepted normally.
